// File: rtl/register_file_scoreboard.sv
// rtl/register_file_scoreboard.sv - 32x32 MIPS register file with per-register busy scoreboard; REGFILE_BYPASS_EN enables write-first bypass
module register_file_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] Read_Register1,
  input  logic [ADDR_WIDTH-1:0] Read_Register2,
  output logic [DATA_WIDTH-1:0] Read_Data1,
  output logic [DATA_WIDTH-1:0] Read_Data2,
  input  logic [ADDR_WIDTH-1:0] Write_Register,
  input  logic [DATA_WIDTH-1:0] Write_Data,
  input  logic                  RegWrite,
  input  logic                  Issue_Valid,
  input  logic [ADDR_WIDTH-1:0] Issue_Register,
  output logic                  Stall,
  output logic [ADDR_WIDTH:0]   Busy_Count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      busy_next;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  wr_en;
  logic                  iss_en;
  logic [DATA_WIDTH-1:0] arr1;
  logic [DATA_WIDTH-1:0] arr2;
  logic                  src1_busy;
  logic                  src2_busy;

  // r0 is never a write or issue target, so both enables exclude it up front
  assign wr_en  = RegWrite && (Write_Register != '0);
  assign iss_en = Issue_Valid && (Issue_Register != '0);

  // Storage array: cleared on reset, otherwise one write per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[Write_Register] <= Write_Data;
    end
  end

  // Next busy vector: clear on writeback, then set on issue so a newer producer wins
  always_comb begin
    busy_next = busy;
    if (wr_en)  busy_next[Write_Register] = 1'b0;
    if (iss_en) busy_next[Issue_Register] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Population count of the next busy vector, registered alongside it
  always_comb begin
    count_next = '0;
    for (int i = 1; i < DEPTH; i++) begin
      count_next = count_next + {{ADDR_WIDTH{1'b0}}, busy_next[i]};
    end
  end

  // Scoreboard state and its count update together so they never disagree
  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= '0;
      Busy_Count <= '0;
    end else begin
      busy       <= busy_next;
      Busy_Count <= count_next;
    end
  end

  assign arr1 = (Read_Register1 == '0) ? '0 : regs[Read_Register1];
  assign arr2 = (Read_Register2 == '0) ? '0 : regs[Read_Register2];

`ifdef REGFILE_BYPASS_EN
  logic hit1;
  logic hit2;

  assign hit1 = wr_en && (Write_Register == Read_Register1);
  assign hit2 = wr_en && (Write_Register == Read_Register2);

  // Write-first read ports; a source whose writeback lands this cycle is already resolved
  always_comb begin
    Read_Data1 = hit1 ? Write_Data : arr1;
    Read_Data2 = hit2 ? Write_Data : arr2;
    src1_busy  = (Read_Register1 != '0) && busy[Read_Register1] && !hit1;
    src2_busy  = (Read_Register2 != '0) && busy[Read_Register2] && !hit2;
  end
`else
  // Reads see only the array; a same-cycle write becomes visible next cycle
  always_comb begin
    Read_Data1 = arr1;
    Read_Data2 = arr2;
    src1_busy  = (Read_Register1 != '0) && busy[Read_Register1];
    src2_busy  = (Read_Register2 != '0) && busy[Read_Register2];
  end
`endif

  assign Stall = src1_busy || src2_busy;

endmodule

// File: doc/register_file_scoreboard.md
Name: register_file_scoreboard

Overview:
- 32 x 32-bit MIPS general-purpose register file: two combinational read ports, one synchronous write port.
- Consumes the destination selected by the RegDst write-register mux (Write_Register), plus RegWrite and Write_Data from the writeback stage.
- Adds a per-register busy scoreboard for multicycle or long-latency producers. Decode gets a stall signal when a source register still has a write outstanding.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- Read_Register1  input  ADDR_WIDTH  source index rs.
- Read_Register2  input  ADDR_WIDTH  source index rt.
- Read_Data1  output  DATA_WIDTH  contents of Read_Register1.
- Read_Data2  output  DATA_WIDTH  contents of Read_Register2.
- Write_Register  input  ADDR_WIDTH  destination index from the RegDst mux.
- Write_Data  input  DATA_WIDTH  writeback value.
- RegWrite  input  1  write enable.
- Issue_Valid  input  1  an instruction with a pending destination is issuing this cycle.
- Issue_Register  input  ADDR_WIDTH  destination of the issuing instruction.
- Stall  output  1  a source register (rs or rt) is busy.
- Busy_Count  output  ADDR_WIDTH+1  number of registers currently marked busy.

Behaviour:
- Reset (rst=1 at posedge): all registers cleared to 0, all busy bits cleared, Busy_Count=0. Reset takes priority over any same-cycle write or issue. In the cycle after reset, Read_Data1/2=0 and Stall=0.
- Write: if RegWrite=1 and Write_Register!=0, regs[Write_Register] <= Write_Data at posedge. Latency is 1 cycle to the storage array.
- Register 0:
  - Hardwired to 0; writes to it are ignored.
  - Reads of index 0 always return 0.
  - Issue_Register=0 never sets a busy bit.
- Read:
  - Read_DataN is purely combinational from Read_RegisterN and the storage array.
  - Bypass behaviour is defined under Optional Feature.
- Scoreboard, per register i (i != 0):
  - Set when Issue_Valid=1 and Issue_Register=i.
  - Cleared when RegWrite=1 and Write_Register=i.
  - If set and clear hit the same index in one cycle, set wins: the bit stays 1, because the newer producer is still pending.
  - Clearing an already-clear bit is a no-op.
  - Re-issuing to an already-busy register is a no-op; there is no count of pending writes per register.
- Stall (combinational):
  - Asserted when busy[Read_Register1] or busy[Read_Register2] is set, excluding index 0.
  - With the bypass compiled in, a busy source whose writeback is happening this cycle does not stall.
- Busy_Count:
  - Registered population count of the busy bits; reflects the state after the edge.
  - Range 0..31. No overflow is possible.
  - Simultaneous set and clear on different indices leaves the count unchanged.
- Reset mid-operation: pending busy bits are discarded; no writeback is expected afterward.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-first bypass: if RegWrite=1, Write_Register!=0 and Write_Register==Read_RegisterN, then Read_DataN=Write_Data in the same cycle.
  - Stall ignores a busy source that is being cleared this cycle by that same write.
- Undefined:
  - Reads return array contents only. A same-cycle write is visible on the next cycle.
  - Stall follows the busy bits directly.

Test Plan:
- Reset, then read r5/r31 -> Read_Data1=Read_Data2=0, Stall=0, Busy_Count=0.
- Write r5=0xDEADBEEF, next cycle read r5 -> 0xDEADBEEF. Write r0=0x12345678 -> r0 still reads 0.
- Same-cycle write r7=0xA5A5A5A5 with Read_Register1=7:
  - REGFILE_BYPASS_EN defined -> Read_Data1=0xA5A5A5A5 that cycle.
  - Undefined -> old value (0) that cycle, 0xA5A5A5A5 next cycle.
- Issue r9, then Read_Register2=9 -> Stall=1, Busy_Count=1. Writeback r9=0x11 -> next cycle Stall=0, Busy_Count=0, Read_Data2=0x11. With bypass, Stall=0 already in the writeback cycle.
- Issue r3 and writeback r3 in the same cycle -> busy[3] stays 1, Busy_Count=1. Issue r0 -> Busy_Count unchanged.
- Issue r2, r4, r6 on consecutive cycles, assert rst during the r6 issue cycle -> all busy bits clear, Busy_Count=0, registers=0, Stall=0 next cycle.
